// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential integer divider: default widths,
// controller state encodings and the divide-by-zero result fill value.
package div_seq_pkg;

    localparam int DW_DEFAULT  = 32;
    localparam int BPC_DEFAULT = 1;

    // Controller states, kept as plain constants for legacy tooling.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Divide-by-zero: every quotient bit is set, remainder is the raw dividend.
    localparam logic DIV0_Q_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// Combinational radix-2 restoring divider slice: BITS_PER_CYCLE chained
// shift / trial-subtract steps over {partial remainder, dividend shift reg}.
// dvd_out has zeros shifted in; the resolved quotient bits come out on
// q_bits (MSB first) for the caller to merge into the low end.
module div_step
    import div_seq_pkg::*;
#(
    parameter int DW             = DW_DEFAULT,
    parameter int BITS_PER_CYCLE = BPC_DEFAULT
) (
    input  logic [DW-1:0]             rem_in,
    input  logic [DW-1:0]             dvd_in,
    input  logic [DW-1:0]             dsr,
    output logic [DW-1:0]             rem_out,
    output logic [DW-1:0]             dvd_out,
    output logic [BITS_PER_CYCLE-1:0] q_bits
);

    logic [DW-1:0] rem_v;
    logic [DW-1:0] dvd_v;
    logic [DW:0]   shifted;
    logic          ge;

    // Chain the restoring steps; the partial remainder stays below the divisor,
    // so the shifted value needs one extra bit but the difference fits DW bits.
    always_comb begin
        rem_v   = rem_in;
        dvd_v   = dvd_in;
        shifted = '0;
        ge      = 1'b0;
        q_bits  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {rem_v, dvd_v[DW-1]};
            ge      = (shifted >= {1'b0, dsr});
            rem_v   = ge ? (shifted[DW-1:0] - dsr) : shifted[DW-1:0];
            dvd_v   = {dvd_v[DW-2:0], 1'b0};
            q_bits[BITS_PER_CYCLE-1-i] = ge;
        end
        rem_out = rem_v;
        dvd_out = dvd_v;
    end

endmodule

// File: rtl/div_seq.sv
// Iterative divider for DIV.W/DIV.WU/MOD.W/MOD.WU sitting in EX0. Operands are
// latched as magnitudes, reduced by div_step, then signs are applied in FIX.
// div_ready holds the EX0/EX1 buffer until the result registers are written.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW             = DW_DEFAULT,
    parameter int BITS_PER_CYCLE = BPC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          issue_valid,
    input  logic          op_signed,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          ex_advance,
    output logic          div_ready,
    output logic          busy,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    localparam int               CNT_W    = $clog2(DW) + 1;
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - BITS_PER_CYCLE);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (DW % BITS_PER_CYCLE) != 0) begin : g_bad_param
        $error("div_seq: BITS_PER_CYCLE must be 1, 2 or 4 and divide DW");
    end

    // Magnitude of a two's-complement operand; INT_MIN maps to 2^(DW-1).
    function automatic logic [DW-1:0] abs_val(input logic signed [DW-1:0] v,
                                              input logic en);
        return (en && v < 0) ? DW'(-v) : DW'(v);
    endfunction

    // Conditional two's-complement negation with natural wrap.
    function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] v,
                                                 input logic neg);
        return neg ? DW'(-v) : v;
    endfunction

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DW-1:0]       rem_r;
    logic [DW-1:0]       dvd_r;
    logic [DW-1:0]       dsr_r;
    logic                sign_q;
    logic                sign_r;
    logic                div0;
    logic [DW-1:0]       step_rem;
    logic [DW-1:0]       step_dvd;
    logic [BITS_PER_CYCLE-1:0] step_q;
    logic                accept;

    assign accept    = (state == S_IDLE) && issue_valid && !flush;
    assign div_ready = (state == S_DONE);
    assign busy      = (state == S_BUSY);

    div_step #(
        .DW             (DW),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem_in  (rem_r),
        .dvd_in  (dvd_r),
        .dsr     (dsr_r),
        .rem_out (step_rem),
        .dvd_out (step_dvd),
        .q_bits  (step_q)
    );

    // Controller, iteration counter and architectural result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_valid) begin
                        cnt   <= '0;
                        state <= (divisor == '0) ? S_FIX : S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + CNT_STEP;
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div0) begin
                        quotient  <= {DW{DIV0_Q_FILL}};
                        remainder <= dvd_r;
                    end else begin
                        quotient  <= apply_sign(dvd_r, sign_q);
                        remainder <= apply_sign(rem_r, sign_r);
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    // A same-cycle issue_valid still belongs to this instruction.
                    if (ex_advance) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture and shift-subtract datapath; stale contents are harmless
    // because the controller never consumes them outside a live operation.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= op_signed && (dividend[DW-1] ^ divisor[DW-1]);
            sign_r <= op_signed && dividend[DW-1];
            div0   <= (divisor == '0);
            dvd_r  <= (divisor == '0) ? dividend : abs_val(dividend, op_signed);
            dsr_r  <= abs_val(divisor, op_signed);
            rem_r  <= '0;
        end else if (state == S_BUSY) begin
            rem_r <= step_rem;
            dvd_r <= step_dvd | {{(DW-BITS_PER_CYCLE){1'b0}}, step_q};
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a vector table run back to back, plus
// hand-written flush and mid-operation reset sequences.
module tb_div_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          issue_valid;
    logic          op_signed;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          ex_advance;
    logic          div_ready;
    logic          busy;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;

    int n_run  = 0;
    int n_fail = 0;

    logic [DW-1:0] last_q;
    logic [DW-1:0] last_r;

    typedef struct {
        logic          sgn;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        int            lat;
        int            hold;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    div_seq #(.DW(DW), .BITS_PER_CYCLE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_valid (issue_valid),
        .op_signed   (op_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .ex_advance  (ex_advance),
        .div_ready   (div_ready),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op (accepted at the next edge), wait for div_ready, check
    // latency, busy count and results, hold, then advance out of DONE.
    task automatic run_op(input string tag, input logic sgn, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] q,
                          input logic [DW-1:0] r, input int lat, input int hold);
        int cyc;
        int nbusy;
        bit done;
        @(negedge clk);
        ex_advance  = 1'b0;
        issue_valid = 1'b1;
        op_signed   = sgn;
        dividend    = a;
        divisor     = b;
        cyc   = 0;
        nbusy = 0;
        done  = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) nbusy++;
            if (div_ready) done = 1'b1;
        end
        check($sformatf("%s latency", tag), DW'(cyc), DW'(lat));
        check($sformatf("%s busy_cycles", tag), DW'(nbusy), DW'((lat == 2) ? 0 : lat - 2));
        check($sformatf("%s quotient", tag), quotient, q);
        check($sformatf("%s remainder", tag), remainder, r);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s hold_ready[%0d]", tag, i), DW'(div_ready), 32'd1);
        end
        @(negedge clk);
        ex_advance = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("%s ready_after_advance", tag), DW'(div_ready), 32'd0);
        check($sformatf("%s busy_after_advance", tag), DW'(busy), 32'd0);
        last_q = q;
        last_r = r;
    endtask

    initial begin
        //          sgn   a             b             q             r             lat hold
        vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        34, 5};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34, 1};
        vecs[2]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        34, 1};
        vecs[3]  = '{1'b0, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 2,  1};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        34, 1};
        vecs[5]  = '{1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        34, 0};
        vecs[6]  = '{1'b0, 32'd10,       32'd4,        32'd2,        32'd2,        34, 0};
        vecs[7]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        34, 0};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34, 0};
        vecs[9]  = '{1'b1, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF0, 2,  0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        34, 0};
        vecs[11] = '{1'b0, 32'd5,        32'hFFFFFFFF, 32'd0,        32'd5,        34, 0};
        vecs[12] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        34, 0};
        vecs[13] = '{1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        34, 0};

        rst         = 1'b1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        op_signed   = 1'b0;
        dividend    = '0;
        divisor     = '0;
        ex_advance  = 1'b0;
        last_q      = '0;
        last_r      = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset div_ready", DW'(div_ready), 32'd0);
        check("reset busy", DW'(busy), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 14; k++) begin
            run_op($sformatf("vec%0d", k), vecs[k].sgn, vecs[k].a, vecs[k].b,
                   vecs[k].q, vecs[k].r, vecs[k].lat, vecs[k].hold);
        end

        @(negedge clk);
        ex_advance  = 1'b0;
        issue_valid = 1'b0;

        // Flush during BUSY: results keep the previous values, nothing completes.
        begin
            bit saw_ready;
            saw_ready = 1'b0;
            @(negedge clk);
            issue_valid = 1'b1;
            op_signed   = 1'b0;
            dividend    = 32'd100;
            divisor     = 32'd7;
            for (int c = 1; c <= 10; c++) begin
                @(posedge clk);
                #1;
                if (div_ready) saw_ready = 1'b1;
            end
            check("flush busy_at_c10", DW'(busy), 32'd1);
            @(negedge clk);
            flush       = 1'b1;
            issue_valid = 1'b0;
            @(posedge clk);
            #1;
            flush = 1'b0;
            check("flush busy_at_c11", DW'(busy), 32'd0);
            check("flush ready_at_c11", DW'(div_ready), 32'd0);
            check("flush no_early_ready", DW'(saw_ready), 32'd0);
            check("flush quotient_kept", quotient, last_q);
            check("flush remainder_kept", remainder, last_r);
            run_op("post_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);
        end

        @(negedge clk);
        ex_advance  = 1'b0;
        issue_valid = 1'b0;

        // Reset in the middle of BUSY clears everything on the next edge.
        begin
            @(negedge clk);
            issue_valid = 1'b1;
            op_signed   = 1'b1;
            dividend    = 32'hFFFFFF9C;
            divisor     = 32'd7;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk);
                #1;
            end
            check("rst busy_at_c20", DW'(busy), 32'd1);
            @(negedge clk);
            rst         = 1'b1;
            issue_valid = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check("rst busy", DW'(busy), 32'd0);
            check("rst div_ready", DW'(div_ready), 32'd0);
            check("rst quotient", quotient, 32'd0);
            check("rst remainder", remainder, 32'd0);
            // -100 / 7 signed: q = -14, r = -2
            run_op("post_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 34, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
